// File: rtl/mul_result_stage_if.sv
// Bundle between the M/W pipeline control and the multiply result stage.
// The pipeline side drives the M-stage product and controls; the stage returns W-stage results.
interface mul_result_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic                stallw;
   logic                flushw;
   logic                mulm;
   logic [2:0]          funct3m;
   logic                w64m;
   logic [4:0]          rdm;
   logic [2*XLEN-1:0]   prodm;
   logic [4:0]          rs1e;
   logic [4:0]          rs2e;
   logic                muldepstalle;
   logic [XLEN-1:0]     mulresultw;
   logic                mulvalidw;
   logic [4:0]          mulrdw;

   modport master (
      output stallw, flushw, mulm, funct3m, w64m, rdm, prodm, rs1e, rs2e,
      input  muldepstalle, mulresultw, mulvalidw, mulrdw
   );

   modport slave (
      input  stallw, flushw, mulm, funct3m, w64m, rdm, prodm, rs1e, rs2e,
      output muldepstalle, mulresultw, mulvalidw, mulrdw
   );
endinterface

// File: rtl/mul_result_stage.sv
// Selects MUL/MULH/MULHSU/MULHU/MULW from the full product, registers it into W,
// and flags E-stage readers of a multiply still sitting in M.
module mul_result_stage #(
   parameter int unsigned XLEN = 64
) (
   input logic                clk,
   input logic                reset,
   mul_result_stage_if.slave  bus
);

   logic            w64_eff;
   logic [XLEN-1:0] res_m;
   logic [XLEN-1:0] result_q;
   logic            valid_q;
   logic [4:0]      rd_q;

   // Word ops only exist on RV64; on RV32 the W64 input is ignored.
   if (XLEN == 64) begin : g_rv64
      assign w64_eff = bus.w64m;
   end else begin : g_rv32
      assign w64_eff = 1'b0;
   end

   always_comb begin
      res_m = bus.prodm[XLEN-1:0];
      if (w64_eff) begin
         res_m = XLEN'({{32{bus.prodm[31]}}, bus.prodm[31:0]});
      end else if (bus.funct3m != 3'b000) begin
         res_m = bus.prodm[2*XLEN-1:XLEN];
      end
   end

   // The product only exists after the M-stage adders, so a dependent E instruction waits.
   assign bus.muldepstalle = bus.mulm & (bus.rdm != 5'd0) &
                             ((bus.rs1e == bus.rdm) | (bus.rs2e == bus.rdm));

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         valid_q  <= 1'b0;
         rd_q     <= 5'd0;
      end else if (!bus.stallw) begin
         if (bus.flushw) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            rd_q     <= 5'd0;
         end else begin
            result_q <= res_m;
            valid_q  <= bus.mulm;
            rd_q     <= bus.rdm;
         end
      end
   end

   assign bus.mulresultw = result_q;
   assign bus.mulvalidw  = valid_q;
   assign bus.mulrdw     = rd_q;

endmodule

// File: tb/tb_mul_result_stage.sv
// Self-checking bench for mul_result_stage: directed vector table, hand-written stall/flush/reset
// sequences, and a randomized run against a behavioural model.
module tb_mul_result_stage;

   localparam int unsigned XLEN = 64;
   localparam logic [127:0] P = {64'h0000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000};
   localparam logic [127:0] Q = {64'h0000_0000_0000_0001, 64'hABCD_0000_7FFF_FFFF};

   logic clk = 1'b0;
   logic reset;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   mul_result_stage_if #(.XLEN(XLEN)) bus ();

   mul_result_stage #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic         mulm;
      logic [2:0]   f3;
      logic         w64;
      logic [4:0]   rd;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [127:0] prod;
      logic         stall;
      logic [63:0]  res;
      logic         valid;
      logic [4:0]   wrd;
      logic         chk_data;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input logic mulm, input logic [2:0] f3, input logic w64,
                          input logic [4:0] rd, input logic [127:0] prod);
      bus.mulm    = mulm;
      bus.funct3m = f3;
      bus.w64m    = w64;
      bus.rdm     = rd;
      bus.prodm   = prod;
   endtask

   task automatic check_w(input string name, input logic [63:0] res, input logic valid,
                          input logic [4:0] rd);
      check({name, ".valid"},  {63'd0, bus.mulvalidw}, {63'd0, valid});
      check({name, ".result"}, bus.mulresultw, res);
      check({name, ".rd"},     {59'd0, bus.mulrdw}, {59'd0, rd});
   endtask

   // Architectural result from the instruction's meaning, not from the RTL structure.
   function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w64,
                                           input logic [127:0] p);
      logic signed [31:0] lo;
      logic signed [63:0] ext;
      if (w64) begin
         lo  = p[31:0];
         ext = lo;
         return ext;
      end
      if (f3 == 3'b000) return p[63:0];
      return 64'(p >> 64);
   endfunction

   vec_t vecs[10];

   logic [63:0] m_res;
   logic        m_valid;
   logic [4:0]  m_rd;

   initial begin
      vecs[0] = '{1'b1, 3'd0, 1'b0, 5'd5,  5'd0, 5'd0, P, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd5,  1'b1};
      vecs[1] = '{1'b1, 3'd3, 1'b0, 5'd6,  5'd6, 5'd0, P, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 5'd6,  1'b1};
      vecs[2] = '{1'b1, 3'd1, 1'b0, 5'd6,  5'd0, 5'd6, P, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 5'd6,  1'b1};
      vecs[3] = '{1'b1, 3'd2, 1'b0, 5'd8,  5'd8, 5'd8, P, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 5'd8,  1'b1};
      vecs[4] = '{1'b1, 3'd0, 1'b1, 5'd9,  5'd0, 5'd0, P, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd9,  1'b1};
      vecs[5] = '{1'b1, 3'd3, 1'b1, 5'd10, 5'd1, 5'd2, Q, 1'b0, 64'h0000_0000_7FFF_FFFF, 1'b1, 5'd10, 1'b1};
      vecs[6] = '{1'b1, 3'd0, 1'b0, 5'd7,  5'd7, 5'd3, P, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd7,  1'b1};
      vecs[7] = '{1'b1, 3'd1, 1'b0, 5'd7,  5'd3, 5'd7, Q, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 5'd7,  1'b1};
      vecs[8] = '{1'b1, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, Q, 1'b0, 64'hABCD_0000_7FFF_FFFF, 1'b1, 5'd0,  1'b1};
      vecs[9] = '{1'b0, 3'd0, 1'b0, 5'd7,  5'd7, 5'd0, P, 1'b0, 64'h0,                   1'b0, 5'd0,  1'b0};

      reset       = 1'b1;
      bus.stallw  = 1'b0;
      bus.flushw  = 1'b0;
      bus.rs1e    = 5'd0;
      bus.rs2e    = 5'd0;
      drive_m(1'b1, 3'd0, 1'b0, 5'd4, P);
      tick();
      tick();
      check_w("reset_state", 64'h0, 1'b0, 5'd0);

      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_m(vecs[i].mulm, vecs[i].f3, vecs[i].w64, vecs[i].rd, vecs[i].prod);
         bus.rs1e = vecs[i].rs1;
         bus.rs2e = vecs[i].rs2;
         #1;
         check($sformatf("vec%0d.depstall", i), {63'd0, bus.muldepstalle}, {63'd0, vecs[i].stall});
         tick();
         check($sformatf("vec%0d.valid", i), {63'd0, bus.mulvalidw}, {63'd0, vecs[i].valid});
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d.result", i), bus.mulresultw, vecs[i].res);
            check($sformatf("vec%0d.rd", i), {59'd0, bus.mulrdw}, {59'd0, vecs[i].wrd});
         end
      end

      // Stall for three cycles with a flush on the second: W must hold, flush waits.
      bus.rs1e = 5'd0;
      bus.rs2e = 5'd0;
      drive_m(1'b1, 3'd0, 1'b0, 5'd5, P);
      tick();
      check_w("stall_load", 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd5);
      drive_m(1'b1, 3'd3, 1'b0, 5'd12, Q);
      for (int c = 0; c < 3; c++) begin
         bus.stallw = 1'b1;
         bus.flushw = (c == 1);
         tick();
         check_w($sformatf("stall_hold%0d", c), 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd5);
      end
      bus.stallw = 1'b0;
      bus.flushw = 1'b1;
      tick();
      check_w("flush_after_stall", 64'h0, 1'b0, 5'd0);
      bus.flushw = 1'b0;

      // Reset beats a stall on a valid W entry.
      drive_m(1'b1, 3'd1, 1'b0, 5'd11, P);
      tick();
      check_w("pre_reset", 64'h1, 1'b1, 5'd11);
      bus.stallw = 1'b1;
      reset      = 1'b1;
      tick();
      check_w("reset_over_stall", 64'h0, 1'b0, 5'd0);
      reset      = 1'b0;
      bus.stallw = 1'b0;
      drive_m(1'b1, 3'd0, 1'b0, 5'd3, Q);
      tick();
      check_w("post_reset", 64'hABCD_0000_7FFF_FFFF, 1'b1, 5'd3);

      // Randomized run against the model.
      m_res   = 64'hABCD_0000_7FFF_FFFF;
      m_valid = 1'b1;
      m_rd    = 5'd3;
      for (int n = 0; n < 10000; n++) begin
         logic         r_mulm, r_w64, r_stall, r_flush, r_reset, exp_dep;
         logic [2:0]   r_f3;
         logic [4:0]   r_rd, r_rs1, r_rs2;
         logic [127:0] r_prod;
         r_mulm  = ($urandom_range(0, 3) != 0);
         r_f3    = 3'($urandom_range(0, 3));
         r_w64   = ($urandom_range(0, 3) == 0);
         r_rd    = 5'($urandom_range(0, 7));
         r_rs1   = 5'($urandom_range(0, 7));
         r_rs2   = 5'($urandom_range(0, 7));
         r_prod  = {$urandom, $urandom, $urandom, $urandom};
         r_stall = ($urandom_range(0, 4) == 0);
         r_flush = ($urandom_range(0, 9) == 0);
         r_reset = ($urandom_range(0, 49) == 0);
         drive_m(r_mulm, r_f3, r_w64, r_rd, r_prod);
         bus.rs1e   = r_rs1;
         bus.rs2e   = r_rs2;
         bus.stallw = r_stall;
         bus.flushw = r_flush;
         reset      = r_reset;
         #1;
         exp_dep = r_mulm && (r_rd != 5'd0) && ((r_rs1 == r_rd) || (r_rs2 == r_rd));
         check("rand.depstall", {63'd0, bus.muldepstalle}, {63'd0, exp_dep});
         if (r_reset) begin
            m_res = 64'h0; m_valid = 1'b0; m_rd = 5'd0;
         end else if (!r_stall) begin
            if (r_flush) begin
               m_res = 64'h0; m_valid = 1'b0; m_rd = 5'd0;
            end else begin
               m_res = ref_res(r_f3, r_w64, r_prod); m_valid = r_mulm; m_rd = r_rd;
            end
         end
         tick();
         check("rand.valid", {63'd0, bus.mulvalidw}, {63'd0, m_valid});
         if (m_valid) begin
            check("rand.result", bus.mulresultw, m_res);
            check("rand.rd", {59'd0, bus.mulrdw}, {59'd0, m_rd});
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
